fetch_unit: RTL and testbench

//   Instruction-fetch stage of the RISC-V core: owns the PC, issues requests to instruction memory,
//   and hands {pc, instr} downstream through a one-entry output buffer with valid/ready.

---
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// presents {pc, instr} through a one-entry valid/ready buffer.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter bit          WORD_ADDR = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    typedef enum logic [0:0] {
        StReq,
        StWait
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        drop_q, drop_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;

    logic        req_ok;
    logic        issue;
    logic        load;

    // A request only goes out when the buffer can take its response.
    assign req_ok = (state_q == StReq) && (!if_valid_q || if_ready) && !redirect;
    assign issue  = req_ok && imem_gnt;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        drop_d        = drop_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        load          = 1'b0;

        unique case (state_q)
            StReq: begin
                if (issue) begin
                    inflight_pc_d = pc_q;
                    pc_d          = pc_q + 32'd4;
                    state_d       = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    state_d = StReq;
                    drop_d  = 1'b0;
                    load    = !drop_q && !redirect;
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = StReq;
        endcase

        if (load) begin
            if_valid_d = 1'b1;
            if_pc_d    = inflight_pc_q;
            if_instr_d = imem_rdata;
        end else if (if_valid_q && if_ready) begin
            if_valid_d = 1'b0;
        end

        if (redirect) begin
            pc_d       = redirect_target & 32'hFFFF_FFFC;
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StReq;
            pc_q          <= RESET_PC;
            inflight_pc_q <= 32'h0;
            drop_q        <= 1'b0;
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'h0;
            if_instr_q    <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            drop_q        <= drop_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
        end
    end

    assign imem_req  = req_ok && !reset;
    assign imem_addr = WORD_ADDR ? {2'b00, pc_q[31:2]} : pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = reset ? 32'h0 : if_pc_q;
    assign if_instr  = reset ? 32'h0 : if_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a random-latency memory and a transaction-level
// model of the fetch stage (next PC, outstanding request, output buffer).
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    always #5 clock = ~clock;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .WORD_ADDR(1'b1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Reference model state
    logic [31:0] m_pc, m_out_pc, m_bpc, m_binstr;
    bit          m_out, m_drop, m_bv;
    bit          exp_req;
    // Memory model state
    bit          mem_busy;
    int          mem_delay;
    logic [31:0] mem_pc;
    // Sampled DUT request
    logic        s_req;
    logic [31:0] s_addr;

    initial begin
        bit load, grant, rst_done;
        rst_done = 0;
        reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_target = 32'h0; if_ready = 1'b0;
        m_pc = RESET_PC; m_out_pc = 0; m_bpc = 0; m_binstr = 0;
        m_out = 0; m_drop = 0; m_bv = 0; mem_busy = 0; mem_delay = 0; mem_pc = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            reset = (cyc < 2);
            if (cyc >= 1500 && !rst_done && m_out) begin
                reset    = 1'b1;
                rst_done = 1;
            end
            if_ready = ($urandom_range(0, 9) < 6);
            redirect = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_target = 32'hFFFF_FFFC;
                1:       redirect_target = 32'h0000_0103;
                default: redirect_target = $urandom;
            endcase
            imem_gnt = ($urandom_range(0, 2) != 0);
            // Directed: jump near the top of the address space, then stream to wrap.
            if (cyc == 20) begin
                redirect = 1'b1; redirect_target = 32'hFFFF_FFF9;
            end else if (cyc > 20 && cyc <= 40) begin
                redirect = 1'b0; imem_gnt = 1'b1; if_ready = 1'b1;
            end
            // Directed: long stall, redirect while stalled.
            if (cyc >= 60 && cyc < 80) begin
                if_ready = 1'b0;
                redirect = (cyc == 75);
            end
            if (reset) redirect = 1'b0;
            imem_rvalid = !reset && mem_busy && (mem_delay == 0);
            imem_rdata  = imem_rvalid ? mem_word(mem_pc) : $urandom;

            exp_req = !reset && !m_out && (!m_bv || if_ready) && !redirect;
            #1;
            s_req  = imem_req;
            s_addr = imem_addr;
            check_eq("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
            if (exp_req) check_eq("imem_addr", imem_addr, {2'b00, m_pc[31:2]});
            if (reset) begin
                check_eq("rst_if_pc", if_pc, 32'h0);
                check_eq("rst_if_instr", if_instr, 32'h0);
            end else begin
                check_eq("if_valid", {31'b0, if_valid}, {31'b0, m_bv});
                if (m_bv) begin
                    check_eq("if_pc", if_pc, m_bpc);
                    check_eq("if_instr", if_instr, m_binstr);
                end
            end

            @(posedge clock);
            if (reset) begin
                m_pc = RESET_PC; m_out = 0; m_drop = 0; m_bv = 0; mem_busy = 0;
            end else begin
                load  = m_out && imem_rvalid && !m_drop && !redirect;
                grant = exp_req && imem_gnt;
                if (m_out && imem_rvalid) begin
                    m_out = 0; m_drop = 0;
                end else if (m_out && redirect) begin
                    m_drop = 1;
                end
                if (grant) begin
                    m_out = 1; m_out_pc = m_pc; m_pc = m_pc + 32'd4;
                end
                if (redirect) m_pc = redirect_target & 32'hFFFF_FFFC;
                if (redirect) m_bv = 0;
                else if (load) begin
                    m_bv = 1; m_bpc = m_out_pc; m_binstr = mem_word(m_out_pc);
                end else if (m_bv && if_ready) m_bv = 0;

                if (imem_rvalid) mem_busy = 0;
                else if (mem_busy) mem_delay--;
                if (s_req && imem_gnt) begin
                    mem_busy  = 1;
                    mem_delay = $urandom_range(0, 2);
                    mem_pc    = {s_addr[29:0], 2'b00};
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
